sw_load_ctrl: RTL and testbench

SW_LOAD_CTRL -- requirements
Module: sw_load_ctrl

---
 rtl/sw_load_ctrl.sv | 106 ++++++++++
 tb/tb_sw_load_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_load_ctrl.sv
// Search-window load controller: issues ROWS reference-memory reads per window and
// tracks the one-cycle-late buffer-chain shifts to flag valid candidate columns.
module sw_load_ctrl #(
   parameter int ROWS     = 23,
   parameter int FILL_LAT = 8,
   parameter int ADDR_W   = 10
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              stall_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              shift_en_o,
   output logic              pe_valid_o,
   output logic [4:0]        cand_row_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        dbg_state_o
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] C_FILL = CNT_W'(FILL_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [CNT_W-1:0]  r_rd_cnt;
   logic [CNT_W-1:0]  r_sh_cnt;
   logic              r_shift;

   logic              w_issue;
   logic              w_pe;
   logic [CNT_W-1:0]  w_cand;

   assign w_issue = (r_state == S_FETCH) && !stall_i;
   assign w_pe    = r_shift && (r_sh_cnt >= C_FILL);
   assign w_cand  = r_sh_cnt - C_FILL;

   // The shift register models the memory's one-cycle read latency, so an issued
   // read always produces its shift even if stall_i rises in the next cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_rd_cnt <= '0;
         r_sh_cnt <= '0;
         r_shift  <= 1'b0;
      end else begin
         r_shift <= w_issue;

         if (r_state == S_IDLE && start_i) begin
            r_sh_cnt <= '0;
         end else if (r_shift && r_sh_cnt != C_LAST) begin
            r_sh_cnt <= r_sh_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state  <= S_FETCH;
                  r_base   <= base_addr_i;
                  r_rd_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (!stall_i) begin
                  if (r_rd_cnt == C_LAST) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_rd_cnt <= r_rd_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_shift && r_sh_cnt == C_LAST) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Address wraps naturally in ADDR_W bits.
   assign rd_en_o     = w_issue;
   assign rd_addr_o   = r_base + ADDR_W'(r_rd_cnt);
   assign shift_en_o  = r_shift;
   assign pe_valid_o  = w_pe;
   assign cand_row_o  = w_pe ? 5'(w_cand) : 5'd0;
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sw_load_ctrl.sv
// Scoreboard bench for sw_load_ctrl: stimulus pushes timed expectations, a negedge
// monitor pops and compares whenever the DUT strobes an output.
module tb_sw_load_ctrl;

   localparam int ROWS     = 23;
   localparam int FILL_LAT = 8;
   localparam int ADDR_W   = 10;

   logic              clk = 1'b0;
   logic              rst_n_i;
   logic              start_i;
   logic [ADDR_W-1:0] base_addr_i;
   logic              stall_i;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic              shift_en_o;
   logic              pe_valid_o;
   logic [4:0]        cand_row_o;
   logic              busy_o;
   logic              done_o;
   logic [1:0]        dbg_state_o;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   logic [41:0] exp_rd_q[$];
   logic [36:0] exp_pe_q[$];
   logic [31:0] exp_sh_q[$];
   logic [31:0] exp_done_q[$];

   sw_load_ctrl #(.ROWS(ROWS), .FILL_LAT(FILL_LAT), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .stall_i     (stall_i),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .shift_en_o  (shift_en_o),
      .pe_valid_o  (pe_valid_o),
      .cand_row_o  (cand_row_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Expected events for one window starting at absolute cycle c0; only events
   // earlier than relative cycle cut are pushed (for windows cut short by reset).
   task automatic push_window(input int c0, input logic [ADDR_W-1:0] base,
                              input int st0, input int stn, input int cut);
      int k;
      logic [ADDR_W-1:0] a;
      k = 1;
      for (int i = 0; i < ROWS; i++) begin
         while (k >= st0 && k < st0 + stn) k++;
         a = base + ADDR_W'(i);
         if (k < cut) exp_rd_q.push_back({32'(c0 + k), a});
         if (k + 1 < cut) begin
            exp_sh_q.push_back(32'(c0 + k + 1));
            if (i >= FILL_LAT - 1)
               exp_pe_q.push_back({32'(c0 + k + 1), 5'(i - (FILL_LAT - 1))});
         end
         k++;
      end
   endtask

   // driver: called at #1 after a posedge; relative cycle 0 is the current cycle
   task automatic drive(input logic [ADDR_W-1:0] base, input int st0, input int stn,
                        input int len, input int e0, input int e1, input int hold);
      for (int k = 0; k <= len; k++) begin
         start_i     = (k == 0) || (k == e0) || (k == e1) || (k < hold);
         stall_i     = (k >= st0) && (k < st0 + stn);
         base_addr_i = (k == 0 || k < hold) ? base : ADDR_W'($urandom_range(0, 1023));
         if (k == 1) check("busy_in_fetch", 64'(busy_o), 64'd1);
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      stall_i = 1'b0;
   endtask

   task automatic check_drained(input string name);
      check({name, "_rd_left"},   64'(exp_rd_q.size()),   64'd0);
      check({name, "_sh_left"},   64'(exp_sh_q.size()),   64'd0);
      check({name, "_pe_left"},   64'(exp_pe_q.size()),   64'd0);
      check({name, "_done_left"}, 64'(exp_done_q.size()), 64'd0);
      check({name, "_idle"},      64'(busy_o),            64'd0);
      exp_rd_q.delete(); exp_sh_q.delete(); exp_pe_q.delete(); exp_done_q.delete();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rd_en_o) begin
         if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(rd_addr_o), 64'hFFFF);
         else check("rd", 64'({32'(cyc), rd_addr_o}), 64'(exp_rd_q.pop_front()));
      end
      if (shift_en_o) begin
         if (exp_sh_q.size() == 0) check("shift_unexpected", 64'(cyc), 64'hFFFF);
         else check("shift_cycle", 64'(cyc), 64'(exp_sh_q.pop_front()));
      end
      if (pe_valid_o) begin
         if (exp_pe_q.size() == 0) check("pe_unexpected", 64'(cand_row_o), 64'hFFFF);
         else check("pe", 64'({32'(cyc), cand_row_o}), 64'(exp_pe_q.pop_front()));
      end else if (cand_row_o != 5'd0) begin
         check("cand_idle_zero", 64'(cand_row_o), 64'd0);
      end
      if (done_o) begin
         if (exp_done_q.size() == 0) check("done_unexpected", 64'(cyc), 64'hFFFF);
         else check("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
      end
   end

   initial begin
      int c0;
      rst_n_i     = 1'b0;
      start_i     = 1'b0;
      stall_i     = 1'b0;
      base_addr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'({rd_en_o, rd_addr_o, shift_en_o, pe_valid_o, cand_row_o, busy_o, done_o}), 64'd0);
      @(posedge clk); #1;
      rst_n_i = 1'b1;
      @(posedge clk); #1;

      // nominal: base 0x040, done at cycle 25
      c0 = cyc;
      push_window(c0, 10'h040, 0, 0, 1000);
      exp_done_q.push_back(32'(c0 + 25));
      drive(10'h040, 0, 0, 28, -1, -1, 0);
      check_drained("nominal");

      // stall cycles 5-7: done delayed to 28
      c0 = cyc;
      push_window(c0, 10'h123, 5, 3, 1000);
      exp_done_q.push_back(32'(c0 + 28));
      drive(10'h123, 5, 3, 31, -1, -1, 0);
      check_drained("stall");

      // address wrap from 0x3F0
      c0 = cyc;
      push_window(c0, 10'h3F0, 0, 0, 1000);
      exp_done_q.push_back(32'(c0 + 25));
      drive(10'h3F0, 0, 0, 28, -1, -1, 0);
      check_drained("wrap");

      // start pulses during FETCH (5) and DONE (25) are ignored
      c0 = cyc;
      push_window(c0, 10'h200, 0, 0, 1000);
      exp_done_q.push_back(32'(c0 + 25));
      drive(10'h200, 0, 0, 30, 5, 25, 0);
      check_drained("ignored_start");

      // back-to-back: start held; second window begins 26 cycles after the first
      c0 = cyc;
      push_window(c0, 10'h055, 0, 0, 1000);
      push_window(c0 + 26, 10'h055, 0, 0, 1000);
      exp_done_q.push_back(32'(c0 + 25));
      exp_done_q.push_back(32'(c0 + 51));
      drive(10'h055, 0, 0, 54, -1, -1, 27);
      check_drained("back_to_back");

      // reset mid-run at cycle 12
      c0 = cyc;
      push_window(c0, 10'h040, 0, 0, 12);
      drive(10'h040, 0, 0, 11, -1, -1, 0);
      rst_n_i = 1'b0;
      @(negedge clk);
      check("midreset_outputs", 64'({rd_en_o, rd_addr_o, shift_en_o, pe_valid_o, cand_row_o, busy_o, done_o}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n_i = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_drained("midreset");

      // fresh window after reset behaves as from power-up
      c0 = cyc;
      push_window(c0, 10'h040, 0, 0, 1000);
      exp_done_q.push_back(32'(c0 + 25));
      drive(10'h040, 0, 0, 28, -1, -1, 0);
      check_drained("post_reset");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
